// File: rtl/f2c_if.sv
// Opcode/entry-state types and the ring/core/response handshake bundle for the
// fabric-to-core responder buffer.
package f2c_pkg;
  typedef enum logic [1:0] {
    OP_RD       = 2'd0,
    OP_WR       = 2'd1,
    OP_WR_BCAST = 2'd2,
    OP_RD_RSP   = 2'd3
  } t_opcode;

  typedef enum logic [2:0] {
    ST_FREE    = 3'd0,
    ST_RD_PEND = 3'd1,
    ST_WR_PEND = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_RDY  = 3'd4,
    ST_DONE    = 3'd5
  } t_state;
endpackage

interface f2c_if;
  import f2c_pkg::*;

  logic          RingReqInValidQ501H;
  logic [9:0]    RingReqInRequestorQ501H;
  t_opcode       RingReqInOpcodeQ501H;
  logic [31:0]   RingReqInAddressQ501H;
  logic [31:0]   RingReqInDataQ501H;
  logic          F2C_ReqAcceptQ501H;
  logic          F2C_FullQ501H;

  logic          F2C_CoreReqValidQ502H;
  t_opcode       F2C_CoreReqOpcodeQ502H;
  logic [31:0]   F2C_CoreReqAddressQ502H;
  logic [31:0]   F2C_CoreReqDataQ502H;
  logic          F2C_CoreReqReadyQ502H;
  logic [31:0]   F2C_CoreRdDataQ503H;

  logic          F2C_RspValidQ502H;
  logic [9:0]    F2C_RspRequestorQ502H;
  t_opcode       F2C_RspOpcodeQ502H;
  logic [31:0]   F2C_RspAddressQ502H;
  logic [31:0]   F2C_RspDataQ502H;
  logic          SelRingRspOutQ502H;

  modport slave (
    input  RingReqInValidQ501H, RingReqInRequestorQ501H, RingReqInOpcodeQ501H,
           RingReqInAddressQ501H, RingReqInDataQ501H,
           F2C_CoreReqReadyQ502H, F2C_CoreRdDataQ503H, SelRingRspOutQ502H,
    output F2C_ReqAcceptQ501H, F2C_FullQ501H,
           F2C_CoreReqValidQ502H, F2C_CoreReqOpcodeQ502H, F2C_CoreReqAddressQ502H,
           F2C_CoreReqDataQ502H,
           F2C_RspValidQ502H, F2C_RspRequestorQ502H, F2C_RspOpcodeQ502H,
           F2C_RspAddressQ502H, F2C_RspDataQ502H
  );

  modport master (
    output RingReqInValidQ501H, RingReqInRequestorQ501H, RingReqInOpcodeQ501H,
           RingReqInAddressQ501H, RingReqInDataQ501H,
           F2C_CoreReqReadyQ502H, F2C_CoreRdDataQ503H, SelRingRspOutQ502H,
    input  F2C_ReqAcceptQ501H, F2C_FullQ501H,
           F2C_CoreReqValidQ502H, F2C_CoreReqOpcodeQ502H, F2C_CoreReqAddressQ502H,
           F2C_CoreReqDataQ502H,
           F2C_RspValidQ502H, F2C_RspRequestorQ502H, F2C_RspOpcodeQ502H,
           F2C_RspAddressQ502H, F2C_RspDataQ502H
  );
endinterface

// File: rtl/f2c.sv
// Fabric-to-core responder buffer: captures ring requests for this core, issues
// them in order to core memory and returns read data to the ring as RD_RSP.
module f2c_entry
  import f2c_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_alloc,
  input  logic [9:0]  i_req,
  input  t_opcode     i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_issue,
  input  logic        i_cap,
  input  logic [31:0] i_cap_data,
  input  logic        i_retire,
  output t_state      o_state,
  output logic [9:0]  o_req,
  output t_opcode     o_op,
  output logic [31:0] o_addr,
  output logic [31:0] o_data
);
  t_state      r_state;
  logic [9:0]  r_req;
  t_opcode     r_op;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  // Events are exclusive per entry: alloc targets a FREE slot, the others
  // each require a distinct non-FREE state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_FREE;
      r_req   <= '0;
      r_op    <= OP_RD;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_alloc) begin
      r_req   <= i_req;
      r_op    <= i_op;
      r_addr  <= i_addr;
      r_data  <= i_data;
      r_state <= (i_op == OP_RD) ? ST_RD_PEND : ST_WR_PEND;
    end else if (i_issue && r_state == ST_RD_PEND) begin
      r_state <= ST_RD_WAIT;
    end else if (i_issue && r_state == ST_WR_PEND) begin
      r_state <= ST_DONE;
    end else if (i_cap && r_state == ST_RD_WAIT) begin
      r_data  <= i_cap_data;
      r_state <= ST_RD_RDY;
    end else if (i_retire && (r_state == ST_DONE || r_state == ST_RD_RDY)) begin
      r_state <= ST_FREE;
    end
  end

  assign o_state = r_state;
  assign o_req   = r_req;
  assign o_op    = r_op;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
endmodule

module f2c
  import f2c_pkg::*;
#(
  parameter int F2C_ENTRIES = 4,
  parameter int F2C_PTR_W   = 2
) (
  input  logic       QClk,
  input  logic       RstQnnnH,
  input  logic [7:0] CoreID,
  f2c_if.slave       bus
);
  localparam int CNT_W = F2C_PTR_W + 1;

  logic [F2C_PTR_W-1:0] r_alloc_ptr, r_iss_ptr, r_ret_ptr, r_rd_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_rd_pend;

  t_state      w_state [F2C_ENTRIES];
  logic [9:0]  w_req   [F2C_ENTRIES];
  t_opcode     w_op    [F2C_ENTRIES];
  logic [31:0] w_addr  [F2C_ENTRIES];
  logic [31:0] w_data  [F2C_ENTRIES];

  logic w_hit, w_full, w_acc, w_iss_vld, w_iss_fire, w_rsp_vld, w_ret;

  // Broadcast writes are taken regardless of target; RD_RSP never matches.
  always_comb begin
    w_hit = 1'b0;
    if (bus.RingReqInValidQ501H) begin
      unique case (bus.RingReqInOpcodeQ501H)
        OP_RD, OP_WR: w_hit = (bus.RingReqInAddressQ501H[31:24] == CoreID);
        OP_WR_BCAST:  w_hit = 1'b1;
        default:      w_hit = 1'b0;
      endcase
    end
  end

  assign w_full     = (r_cnt == CNT_W'(F2C_ENTRIES));
  assign w_acc      = w_hit && !w_full && RstQnnnH;
  assign w_iss_vld  = (w_state[r_iss_ptr] == ST_RD_PEND) || (w_state[r_iss_ptr] == ST_WR_PEND);
  assign w_iss_fire = w_iss_vld && bus.F2C_CoreReqReadyQ502H;
  assign w_rsp_vld  = (w_state[r_ret_ptr] == ST_RD_RDY);
  assign w_ret      = (w_state[r_ret_ptr] == ST_DONE) || (w_rsp_vld && bus.SelRingRspOutQ502H);

  for (genvar i = 0; i < F2C_ENTRIES; i++) begin : g_ent
    f2c_entry u_ent (
      .i_clk      (QClk),
      .i_rst_n    (RstQnnnH),
      .i_alloc    (w_acc && r_alloc_ptr == F2C_PTR_W'(i)),
      .i_req      (bus.RingReqInRequestorQ501H),
      .i_op       (bus.RingReqInOpcodeQ501H),
      .i_addr     (bus.RingReqInAddressQ501H),
      .i_data     (bus.RingReqInDataQ501H),
      .i_issue    (w_iss_fire && r_iss_ptr == F2C_PTR_W'(i)),
      .i_cap      (r_rd_pend && r_rd_idx == F2C_PTR_W'(i)),
      .i_cap_data (bus.F2C_CoreRdDataQ503H),
      .i_retire   (w_ret && r_ret_ptr == F2C_PTR_W'(i)),
      .o_state    (w_state[i]),
      .o_req      (w_req[i]),
      .o_op       (w_op[i]),
      .o_addr     (w_addr[i]),
      .o_data     (w_data[i])
    );
  end

  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      r_alloc_ptr <= '0;
      r_iss_ptr   <= '0;
      r_ret_ptr   <= '0;
      r_rd_idx    <= '0;
      r_rd_pend   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_acc)      r_alloc_ptr <= r_alloc_ptr + F2C_PTR_W'(1);
      if (w_iss_fire) r_iss_ptr   <= r_iss_ptr + F2C_PTR_W'(1);
      if (w_ret)      r_ret_ptr   <= r_ret_ptr + F2C_PTR_W'(1);
      // Read data lands exactly one cycle after the RD handshake.
      r_rd_pend <= w_iss_fire && (w_state[r_iss_ptr] == ST_RD_PEND);
      if (w_iss_fire && w_state[r_iss_ptr] == ST_RD_PEND) r_rd_idx <= r_iss_ptr;
      unique case ({w_acc, w_ret})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.F2C_ReqAcceptQ501H      = w_acc;
  assign bus.F2C_FullQ501H           = w_full;
  assign bus.F2C_CoreReqValidQ502H   = w_iss_vld;
  assign bus.F2C_CoreReqOpcodeQ502H  = (w_op[r_iss_ptr] == OP_RD) ? OP_RD : OP_WR;
  assign bus.F2C_CoreReqAddressQ502H = w_addr[r_iss_ptr];
  assign bus.F2C_CoreReqDataQ502H    = w_data[r_iss_ptr];
  assign bus.F2C_RspValidQ502H       = w_rsp_vld;
  assign bus.F2C_RspRequestorQ502H   = w_req[r_ret_ptr];
  assign bus.F2C_RspOpcodeQ502H      = OP_RD_RSP;
  assign bus.F2C_RspAddressQ502H     = w_addr[r_ret_ptr];
  assign bus.F2C_RspDataQ502H        = w_data[r_ret_ptr];

  ap_rd_cap: assert property (@(posedge QClk) disable iff (!RstQnnnH)
    r_rd_pend |-> (w_state[r_rd_idx] == ST_RD_WAIT));
  ap_no_rsp_op: assert property (@(posedge QClk) disable iff (!RstQnnnH)
    (w_state[r_ret_ptr] != ST_FREE) |-> (w_op[r_ret_ptr] != OP_RD_RSP));
endmodule

// File: doc/f2c.md
Name: f2c

Overview:
Fabric-to-Core responder buffer; receiving end of the ring request protocol that the core-side request buffer initiates.
- Captures ring requests addressed to this core: RD, WR and any WR_BCAST.
- Issues them in arrival order to the local core memory port.
- Returns read data to the ring as RD_RSP, tagged with the original requestor and address.
- Sits in the RC between ring-in and the core memory interface, in parallel with the core-side request buffer.

Parameters:
F2C_ENTRIES, 4, number of buffer entries (power of 2).
F2C_PTR_W, 2, log2(F2C_ENTRIES).

Ports:
QClk  in  1  clock
RstQnnnH  in  1  asynchronous active-low reset
CoreID  in  8  this core's ID
RingReqInValidQ501H  in  1  ring request valid
RingReqInRequestorQ501H  in  10  requestor tag
RingReqInOpcodeQ501H  in  t_opcode  RD/WR/WR_BCAST/RD_RSP
RingReqInAddressQ501H  in  32  address; [31:24] = target core
RingReqInDataQ501H  in  32  write data
F2C_ReqAcceptQ501H  out  1  request captured this cycle
F2C_FullQ501H  out  1  all entries occupied
F2C_CoreReqValidQ502H  out  1  request to core memory
F2C_CoreReqOpcodeQ502H  out  t_opcode  RD or WR (WR_BCAST presented as WR)
F2C_CoreReqAddressQ502H  out  32  core address
F2C_CoreReqDataQ502H  out  32  core write data
F2C_CoreReqReadyQ502H  in  1  core accepts request
F2C_CoreRdDataQ503H  in  32  read data, exactly 1 cycle after RD handshake
F2C_RspValidQ502H  out  1  RD_RSP ready for ring
F2C_RspRequestorQ502H  out  10  original requestor
F2C_RspOpcodeQ502H  out  t_opcode  constant RD_RSP
F2C_RspAddressQ502H  out  32  original address
F2C_RspDataQ502H  out  32  read data
SelRingRspOutQ502H  in  1  ring out-mux grants F2C response this cycle

Behaviour:
Reset:
- Asynchronous on RstQnnnH low.
- All entry states FREE; AllocPtr, IssPtr and RetPtr = 0; Count = 0.
- All valid/accept/full outputs 0. Data outputs don't-care but driven from entry 0.

Entry states: FREE, RD_PEND, WR_PEND, RD_WAIT, RD_RDY, DONE.

Accept:
- Hit = Valid && ((Opcode ∈ {RD,WR} && Address[31:24]==CoreID) || Opcode==WR_BCAST).
- RD_RSP is never accepted.
- Accept = Hit && !Full, where Full = (Count == F2C_ENTRIES) from the registered Count; no same-cycle bypass of a retire.
- On accept, write requestor/address/data/opcode into entry[AllocPtr]; state ← RD_PEND (RD) or WR_PEND (WR, WR_BCAST); AllocPtr++ with wrap.
- A rejected request is left for the ring to recirculate; F2C holds no state for it.

Issue (in order):
- CoreReqValid = state[IssPtr] ∈ {RD_PEND, WR_PEND}, combinational from registered state.
- On Valid && Ready: WR_PEND→DONE; RD_PEND→RD_WAIT; IssPtr++.
- On an RD issue, register the issued index and a pending flag.
- Next cycle, F2C_CoreRdDataQ503H is written to entry[index]; RD_WAIT→RD_RDY.
- Issue is blocked while state[IssPtr] is FREE or IssPtr has caught up to AllocPtr with Count counted.

Retire (in order, at most one per cycle):
- DONE at RetPtr → FREE, RetPtr++, no ring traffic.
- RspValid = state[RetPtr]==RD_RDY; outputs are driven from entry[RetPtr].
- On SelRingRspOutQ502H && RspValid: RD_RDY→FREE, RetPtr++.
- A grant while RspValid=0 is ignored.
- An ungranted RD_RDY entry holds indefinitely and blocks younger retires.

Count:
- +1 on accept, −1 on retire.
- Accept and retire in the same cycle leave Count unchanged.
- Pointers wrap modulo F2C_ENTRIES.

Same-cycle events: accept, issue, read-data capture and retire may all occur in one cycle on distinct entries without interference.

Latency:
- Ring accept (Q501H) → earliest core issue next cycle (Q502H).
- Read data Q503H → earliest RspValid the following cycle.

Protocol violations (opcode RD_RSP in an entry, read data with no pending read): state unchanged; flagged by assertion.

Test Plan:
1. Reset mid-operation with 3 entries occupied → next cycle all outputs 0, Count=0, pointers 0.
2. CoreID=0x02, RD addr 0x0200_0010, requestor 0x045; core Ready=1; read data 0xDEADBEEF → CoreReqValid at +1, RspValid at +3 with requestor 0x045, addr 0x0200_0010, data 0xDEADBEEF, opcode RD_RSP; entry freed on grant.
3. RD to addr 0x0300_0000 with CoreID=0x02 → no accept; WR_BCAST to 0x0300_0000 → accepted and issued to core as WR.
4. Four RDs, Ready=1, grant held low → Full=1; fifth RD rejected (Accept=0). Pulse grant → one retire; request presented the cycle after the retire is accepted.
5. RD then WR back-to-back, grant held low → WR issued to core (IssPtr passes), but the WR entry stays DONE until the RD retires via grant; both then free in order.
6. Ready=0 for 5 cycles with 2 WRs queued → CoreReqValid held with stable address/data; both WRs issue and retire on consecutive cycles once Ready=1.
